// File: rtl/channel_deserializer.sv
// Purpose: packs K consecutive N-bit input words into one K*N-bit output word (first word in the LSBs).
// Latency: out_v rises one clk after the final word of a group is accepted; out_d is a register output.
// Backpressure: non-final words are always accepted; the final word waits (in_a=0) until the output register is free or being drained.
// Optional feature macro: CHANNEL_DESERIALIZER_FLUSH_EN adds a flush input that emits a zero-padded partial word.
module channel_deserializer #(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_v,
   input  logic [N-1:0]   in_d,
   output logic           in_a,
   output logic           out_v,
   output logic [K*N-1:0] out_d,
   input  logic           out_a
`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
   ,
   input  logic           flush
`endif
);

   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   logic [(K-1)*N-1:0] asm;
   logic [CW-1:0]      cnt;
   logic [K*N-1:0]     obuf;
   logic               ov;

   logic               last_word;
   logic               out_free;
   logic               in_xfer;
   logic               out_xfer;
   logic               load_full;
   logic               load;
   logic               flush_fire;
   logic [K*N-1:0]     load_word;

   assign last_word = (cnt == LAST);
   // The output register can take a new word if empty or emptying this cycle.
   assign out_free  = ~ov | out_a;

`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
   logic           flush_pend;
   logic [K*N-1:0] flush_word;

   // Partial word: only slices written since cnt=0 are kept, the rest are zero.
   always_comb begin
      flush_word = '0;
      for (int j = 0; j < K - 1; j++) begin
         if (j < int'(cnt)) begin
            flush_word[j*N +: N] = asm[j*N +: N];
         end
      end
   end

   assign flush_fire = flush_pend & out_free;
   // Input is frozen while a flush waits for the output register.
   assign in_a       = in_v & ~flush_pend & (~last_word | out_free);
   assign load_word  = load_full ? {in_d, asm} : flush_word;

   // Flush request latch; a flush coinciding with a final word is just a normal emission.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_pend <= 1'b0;
      end else if (flush_fire) begin
         flush_pend <= 1'b0;
      end else if (flush && !load_full && ((cnt != '0) || in_xfer)) begin
         flush_pend <= 1'b1;
      end
   end
`else
   assign flush_fire = 1'b0;
   assign in_a       = in_v & (~last_word | out_free);
   assign load_word  = {in_d, asm};
`endif

   assign in_xfer   = in_v & in_a;
   assign out_xfer  = ov & out_a;
   assign load_full = in_xfer & last_word;
   assign load      = load_full | flush_fire;

   // Store non-final words into their slice of the assembly register.
   always_ff @(posedge clk) begin
      if (reset) begin
         asm <= '0;
      end else if (in_xfer && !last_word) begin
         asm[cnt*N +: N] <= in_d;
      end
   end

   // Word counter restarts on every emission (full or flushed).
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (in_xfer) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Output register: a load wins over a drain so back-to-back words keep ov high.
   always_ff @(posedge clk) begin
      if (reset) begin
         obuf <= '0;
         ov   <= 1'b0;
      end else begin
         if (load) begin
            obuf <= load_word;
         end
         if (load) begin
            ov <= 1'b1;
         end else if (out_xfer) begin
            ov <= 1'b0;
         end
      end
   end

   assign out_v = ov;
   assign out_d = obuf;

endmodule

// File: tb/tb_channel_deserializer.sv
// Bench for channel_deserializer with N=8, K=4: directed steps plus a randomised stream.
// Expected packed words are built from the words the bench sends and checked as they leave.
// Flush steps are compiled only when CHANNEL_DESERIALIZER_FLUSH_EN is defined.
module tb_channel_deserializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_v;
   logic [7:0]  in_d;
   logic        in_a;
   logic        out_v;
   logic [31:0] out_d;
   logic        out_a;
   logic        ack_manual;
   logic        rnd_a;
   logic        sink_random;
`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
   logic        flush;
`endif

   int          compared   = 0;
   int          mismatched = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  part[4];
   int          pcount = 0;

   always #5 clk = ~clk;

   assign out_a = sink_random ? rnd_a : ack_manual;

   channel_deserializer #(.N(8), .K(4)) dut (
      .clk   (clk),
      .reset (reset),
      .in_v  (in_v),
      .in_d  (in_d),
      .in_a  (in_a),
      .out_v (out_v),
      .out_d (out_d),
      .out_a (out_a)
`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
      ,
      .flush (flush)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference packing: first word in the low byte.
   task automatic model_word(input logic [7:0] d);
      part[pcount] = d;
      pcount++;
      if (pcount == 4) begin
         exp_q.push_back({part[3], part[2], part[1], part[0]});
         pcount = 0;
      end
   endtask

   // Present one word and wait for its transfer; returns the cycles taken.
   task automatic send(input logic [7:0] d, output int cycles);
      logic acc;
      in_v   = 1'b1;
      in_d   = d;
      cycles = 0;
      acc    = 1'b0;
      while (!acc && cycles < 200) begin
         @(negedge clk);
         acc = in_a;
         @(posedge clk);
         #1;
         cycles++;
      end
      in_v = 1'b0;
      if (!acc) begin
         check("send_timeout", 32'd0, 32'd1);
      end else begin
         model_word(d);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Random sink ready, changed just after each active edge.
   always @(posedge clk) begin
      #1;
      rnd_a = 1'($urandom_range(0, 1));
   end

   // Output monitor and input-acknowledge rule, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (in_a && !in_v) begin
            check("in_a_without_in_v", 32'(in_a), 32'd0);
         end
         if (out_v && out_a) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", out_d, 32'hxxxx_xxxx);
            end else begin
               check("out_word", out_d, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int cyc;
      reset       = 1'b1;
      in_v        = 1'b0;
      in_d        = '0;
      ack_manual  = 1'b1;
      sink_random = 1'b0;
      rnd_a       = 1'b0;
`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
      flush       = 1'b0;
`endif
      idle(3);
      @(negedge clk);
      check("reset_out_v", 32'(out_v), 32'd0);
      check("reset_out_d", out_d, 32'd0);
      check("reset_in_a", 32'(in_a), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);

      // Single group, always-acking sink.
      send(8'h11, cyc);
      send(8'h22, cyc);
      send(8'h33, cyc);
      send(8'h44, cyc);
      check("first_out_v", 32'(out_v), 32'd1);
      check("first_out_d", out_d, 32'h4433_2211);
      idle(1);
      check("first_one_cycle", 32'(out_v), 32'd0);

      // Eight words back to back: each must be accepted in one cycle.
      for (int i = 1; i <= 8; i++) begin
         send(8'(i), cyc);
         check("b2b_accept", 32'(cyc), 32'd1);
      end
      idle(3);

      // Stalled sink: three more words go into assembly, the final one waits.
      ack_manual = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         send(8'(i), cyc);
         check("stall_accept", 32'(cyc), 32'd1);
      end
      in_v = 1'b1;
      in_d = 8'h08;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_a", 32'(in_a), 32'd0);
         check("stall_out_v", 32'(out_v), 32'd1);
         check("stall_out_d", out_d, 32'h0403_0201);
         @(posedge clk);
         #1;
      end
      ack_manual = 1'b1;
      @(negedge clk);
      check("pulse_in_a", 32'(in_a), 32'd1);
      @(posedge clk);
      #1;
      model_word(8'h08);
      in_v       = 1'b0;
      ack_manual = 1'b0;
      check("reload_out_v", 32'(out_v), 32'd1);
      check("reload_out_d", out_d, 32'h0807_0605);
      idle(2);
      ack_manual = 1'b1;
      idle(2);

      // Reset discards a partial word.
      send(8'hAA, cyc);
      send(8'hBB, cyc);
      reset  = 1'b1;
      pcount = 0;
      @(negedge clk);
      check("reset_mid_out_v", 32'(out_v), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("after_reset_out_v", 32'(out_v), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         send(8'(i), cyc);
      end
      idle(3);
      check("reset_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef CHANNEL_DESERIALIZER_FLUSH_EN
      // Flush of a two-word partial group, then a normal group, then an ignored flush.
      send(8'hAA, cyc);
      send(8'hBB, cyc);
      flush = 1'b1;
      exp_q.push_back(32'h0000_BBAA);
      pcount = 0;
      idle(1);
      flush = 1'b0;
      idle(3);
      for (int i = 1; i <= 4; i++) begin
         send(8'(i), cyc);
      end
      idle(2);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(5);
      check("flush_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Random gaps and random sink over 400 counting words.
      sink_random = 1'b1;
      for (int i = 0; i < 400; i++) begin
         idle($urandom_range(0, 5));
         send(8'(i), cyc);
      end
      sink_random = 1'b0;
      ack_manual  = 1'b1;
      idle(20);
      check("random_queue_empty", 32'(exp_q.size()), 32'd0);
      check("random_no_partial", 32'(pcount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/channel_deserializer.md
Name: channel_deserializer

Overview:
- Receiving end of a narrow serial Channel link.
- Collects K consecutive N-bit words from an input Channel and packs them into one K*N-bit word on an output Channel.
- Sits between a narrow transport (board bus / FIFO output) and wide-word consumers such as decoders and routers.
- Holds one complete output word while assembling the next, so it sustains one input word per cycle when the consumer keeps up.

Parameters:
- N, 8, width of each input word in bits.
- K, 4, input words per output word (K >= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- in  Channel receiver  N  narrow input words; in.a driven here.
- out  Channel sender  K*N  packed output words; out.v and out.d driven here.
- flush  input  1  request to emit a partial word; present only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, sampled on posedge clk.
- Channel rule: a transfer occurs on a posedge where .v and .a are both 1.
- State:
  - assembly register asm, (K-1)*N bits.
  - word counter cnt, 0..K-1, width $clog2(K).
  - output register obuf, K*N bits.
  - output-valid flag ov.
- Reset values: cnt=0, asm=0, obuf=0, ov=0. So out.v=0 and out.d=0. Any partially assembled word is discarded.
- Outputs: out.v = ov; out.d = obuf. out.d is stable while out.v=1 and not acked.
- Packing order: the first received word lands in out.d[N-1:0]; word j lands in out.d[(j+1)*N-1 : j*N].
- Non-final word (cnt < K-1):
  - in.a = in.v, independent of output state.
  - On transfer: asm slice cnt <= in.d; cnt <= cnt+1.
- Final word (cnt == K-1):
  - in.a = in.v & (~ov | out.a). in.a is combinational in out.a, as the Channel protocol allows.
  - On transfer: obuf <= {in.d, asm}; ov <= 1; cnt <= 0.
- Output drain: on an out transfer with no simultaneous load, ov <= 0. A simultaneous load plus drain keeps ov=1 and replaces obuf.
- Latency: out.v rises the cycle after the final word's transfer (1 clk).
- Throughput: one input word per cycle with an always-acking sink. Output words may be back-to-back every K cycles.
- Output stall: up to K-1 further words are accepted into asm. The next final word is held off (in.a=0) until out.a.
- in.a is never 1 while in.v=0.
- asm contents after emission are don't-care. Only slices written since cnt=0 are used.
- No combinational path from in.d to out.d; out.d is a register output.

Optional Feature:
- Macro: CHANNEL_DESERIALIZER_FLUSH_EN.
- Defined:
  - flush port exists; a flush_pend register is added (reset 0).
  - A cycle with flush=1 and (cnt>0, or a non-final word transferring that cycle) sets flush_pend.
  - A word transferring in that same cycle is included before the flush takes effect.
  - flush while cnt==0 and no transfer is ignored.
  - While flush_pend=1, in.a=0.
  - Once ~ov | out.a: obuf <= asm's valid slices with unwritten upper slices zero; ov <= 1; cnt <= 0; flush_pend <= 0.
  - If the flush coincides with a final-word transfer, this is a normal full emission and flush_pend is not set.
- Undefined:
  - No flush port, no flush_pend register.
  - Partial words are emitted only after K words.

Test Plan:
- N=8, K=4, sink always acks; send 0x11,0x22,0x33,0x44 back-to-back -> out.v=1 the cycle after the 0x44 transfer; out.d=0x44332211 for exactly one cycle.
- Eight words 0x01..0x08 back-to-back with sink always acking -> in.a high all 8 cycles; outputs 0x04030201 then 0x08070605.
- Sink holds out.a=0 after the first word; send 0x01..0x08 -> 0x05..0x07 accepted; 0x08 stalled (in.a=0) with out.d stable at 0x04030201; one out.a pulse -> 0x08 accepted that cycle; next output 0x08070605.
- After 0xAA,0xBB are accepted, assert reset 1 cycle, then send 0x01..0x04 -> out.v=0 through reset; single output 0x04030201 with no 0xAA/0xBB.
- in.v toggling randomly (0-5 idle cycles), sink acking randomly, 400 words of counting data -> outputs match the reference packing in order; no drop or duplication; in.a never 1 while in.v=0.
- With CHANNEL_DESERIALIZER_FLUSH_EN: send 0xAA,0xBB, pulse flush -> next output 0x0000BBAA, cnt=0; a following 0x01..0x04 gives 0x04030201; flush with cnt==0 -> no output.
